uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single async_transmitter (115200 baud @ 50 MHz) among NREQ byte requesters:
//  command FSM replies, token dispensers and LED controller. Round-robin grant; each granted
//  byte is one start pulse to the transmitter. The next byte is not issued until the current
//  frame has finished.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  TIMEOUT  16    max clk50m cycles to wait for tx_busy to rise after tx_start (TXARB_TIMEOUT_EN)
// PORTS
//  clk50m    in   1        system clock, 50 MHz; sole clock
//  reset     in   1        synchronous, active-high reset
//  req       in   NREQ     req[i]=1: requester i holds a valid byte
//  req_data  in   8*NREQ   byte of requester i at [8*i+7:8*i]; held stable while req[i]=1
//  ack       out  NREQ     one-cycle pulse: byte of requester i latched; drop or replace req
//  tx_start  out  1        to TxD_start; one-cycle pulse
//  tx_data   out  8        to TxD_data; stable from tx_start until frame done
//  tx_busy   in   1        from TxD_busy
//  grant_id  out  3        index of current/last granted requester
//  active    out  1        1 while a byte is being sequenced (state != IDLE)
//  err       out  1        sticky timeout flag (TXARB_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset (sync, high, dominates all): state=IDLE; ack=0, tx_start=0, tx_data=8'h00,
//   grant_id=0, active=0, err=0, rr pointer=0 (requester 0 highest priority).
//   Reset mid-frame: tx_start deasserts; the in-flight frame in the transmitter completes
//   unaffected. The arbiter does not wait for that frame; it re-enters IDLE.
//  FSM states: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   IDLE:      if |req and tx_busy==0: pick winner w (first req set scanning ptr, ptr+1, ...
//              mod NREQ); tx_data<=req_data[w]; ack[w]=1 for this cycle; grant_id<=w;
//              ptr<=(w+1) mod NREQ; go ISSUE. If tx_busy==1 (foreign/leftover frame), stay.
//   ISSUE:     tx_start=1 exactly this cycle; go WAIT_BUSY.
//   WAIT_BUSY: stay until tx_busy==1, then go WAIT_DONE. Does not advance on tx_busy==0
//              (avoids the start/busy race).
//   WAIT_DONE: stay while tx_busy==1; on tx_busy==0 go IDLE.
//  Latency: req rising in IDLE with tx idle -> ack same cycle (combinational from registered
//   state) -> tx_start next cycle. Back-to-back bytes: a new grant is possible the cycle
//   after WAIT_DONE exits (one IDLE cycle minimum between frames).
//  Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0,...
//   No requester waits more than NREQ-1 frames.
//  Simultaneous: several req in one cycle -> only the rr winner is acked. A req withdrawn
//   before its ack is never sent. A req that asserts while a frame is in progress waits.
//  ack is a one-cycle pulse only; a requester keeping req high after ack is treated as a
//   new byte.
//  grant_id width is fixed at 3; for NREQ<8 the upper values are unused.
// CONFIGURATION
//  TXARB_TIMEOUT_EN defined: a counter runs in WAIT_BUSY. When it reaches TIMEOUT cycles
//   without tx_busy, err<=1 (sticky until reset) and the FSM returns to IDLE. The byte is
//   lost; no retry.
//  TXARB_TIMEOUT_EN undefined: no counter; WAIT_BUSY waits indefinitely; err tied 0.
// STRUCTURE
//  Package tx_arb_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2,
//   WAIT_DONE=2'd3); GRANT_W=3; byte width 8.
//  Sub-module rr_priority_pick: combinational, inputs req[NREQ] and ptr, outputs one-hot
//   win[NREQ] and win_id. Reused by the planned dispenser scheduler.
//  Top: FSM, tx_data/grant registers, optional timeout counter.
// TESTING (bench models transmitter: busy rises 1 cycle after start, stays 10 cycles)
//  1 Reset: hold reset 3 cycles with req=4'b1111 -> ack=0, tx_start=0, active=0 throughout;
//    first grant after release goes to req 0.
//  2 Single: req[2]=1, req_data[2]=8'h02 -> ack[2] pulses one cycle; tx_start one cycle
//    later with tx_data=8'h02; the next grant is not before busy falls.
//  3 Round-robin: req=4'b1111, bytes 8'hA0..8'hA3 held high -> tx_data order
//    A0, A1, A2, A3, A0; exactly one tx_start per frame.
//  4 Withdraw/contention: req[1] and req[3] rise together at ptr=2 -> req[3] wins;
//    req[1] dropped before its turn -> no frame ever carries req_data[1].
//  5 Mid-frame reset: assert reset in WAIT_DONE -> next cycle state IDLE, outputs at reset
//    values. Pending req=4'b0001 is not granted until the modelled busy clears.
//  6 TXARB_TIMEOUT_EN, TIMEOUT=16, model never raises busy -> 16 cycles after tx_start:
//    err=1, active=0; next req is still served; err remains 1 until reset.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM encoding, grant and byte widths.
package tx_arb_pkg;

    localparam int GRANT_W = 3;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; slave = arbiter side, master = environment.
interface uart_tx_arbiter_if
    import tx_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0][7:0]    req_data;
    logic [NREQ-1:0]         ack;
    logic                    tx_start;
    byte_t                   tx_data;
    logic                    tx_busy;
    logic [GRANT_W-1:0]      grant_id;
    logic                    active;
    logic                    err;

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_start, tx_data, grant_id, active, err
    );

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_start, tx_data, grant_id, active, err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req scanning ptr, ptr+1, ... mod NREQ.
module rr_priority_pick
    import tx_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NREQ-1:0]    win,
    output logic [GRANT_W-1:0] win_id
);
    int   idx;
    logic found;

    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_id   = GRANT_W'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one async transmitter among NREQ byte requesters.
// Optional TXARB_TIMEOUT_EN: give up (sticky err) if tx_busy never rises after tx_start.
module uart_tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk50m,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    state_t             state, next;
    logic [NREQ-1:0]    win;
    logic [GRANT_W-1:0] win_id;
    logic [PTR_W-1:0]   ptr;
    logic [GRANT_W-1:0] grant_id;
    byte_t              tx_data;
    logic               grant;
    logic               timeout;
    logic [NREQ-1:0]    ack;
    logic               tx_start;
    logic               active;

    rr_priority_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .win    (win),
        .win_id (win_id)
    );

    // A foreign or leftover frame still on the line blocks new grants.
    assign grant = (state == IDLE) && (|bus.req) && !bus.tx_busy;

`ifdef TXARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt;
    logic             err;

    // Counts cycles since tx_start; the ISSUE cycle is the first one.
    always_ff @(posedge clk50m) begin
        if (reset || state == IDLE || state == WAIT_DONE) cnt <= '0;
        else                                              cnt <= cnt + 1'b1;
    end

    assign timeout = (state == WAIT_BUSY) && !bus.tx_busy && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk50m) begin
        if (reset)        err <= 1'b0;
        else if (timeout) err <= 1'b1;
    end

    assign bus.err = err;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk50m) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      if (grant) next = ISSUE;
            ISSUE:     next = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy) next = WAIT_DONE;
                       else if (timeout) next = IDLE;
            WAIT_DONE: if (!bus.tx_busy) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // Outputs are masked during reset so nothing leaks out of a stale state.
    always_comb begin
        ack      = '0;
        tx_start = 1'b0;
        active   = 1'b0;
        if (!reset) begin
            if (grant) ack = win;
            tx_start = (state == ISSUE);
            active   = (state != IDLE);
        end
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            tx_data  <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else if (grant) begin
            tx_data  <= bus.req_data[win_id[PTR_W-1:0]];
            grant_id <= win_id;
            ptr      <= (win_id == GRANT_W'(NREQ - 1)) ? '0 : PTR_W'(win_id + 1'b1);
        end
    end

    assign bus.ack      = ack;
    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data;
    assign bus.grant_id = grant_id;
    assign bus.active   = active;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model (busy 1 cycle after start, 10 cycles long).
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk50m (clk),
        .reset  (rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int bcnt = 0;
    bit no_busy = 1'b0;
    int starts = 0, acks = 0, overlap = 0, unstable = 0;
    logic [7:0] frames[$];
    logic [7:0] cur = 8'h00;

    assign bus.tx_busy = (bcnt != 0);

    // Transmitter model and frame logger; sees pre-edge DUT outputs.
    always @(posedge clk) begin
        if (bus.ack != 4'b0000) acks++;
        if (bus.tx_start) begin
            frames.push_back(bus.tx_data);
            starts++;
            if (bcnt != 0) overlap++;
            cur = bus.tx_data;
        end else if (bcnt != 0 && bus.tx_data != cur) begin
            unstable++;
        end
        if (bus.tx_start && !no_busy) bcnt <= 10;
        else if (bcnt != 0)           bcnt <= bcnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.tx_start) break;
        end
        if (k == 40) chk(tag, 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.active && !bus.tx_busy) break;
        end
        if (k == 40) chk(tag, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int k, a0;
        logic [7:0] exp3 [5];
        exp3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) bus.req_data[i] = 8'hA0 + 8'(i);

        // Reset held with all requests pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", 32'(bus.ack), 32'h0);
            chk("rst_start", 32'(bus.tx_start), 32'h0);
            chk("rst_active", 32'(bus.active), 32'h0);
            if (i == 0) begin
                chk("rst_txdata", 32'(bus.tx_data), 32'h0);
                chk("rst_grant", 32'(bus.grant_id), 32'h0);
                chk("rst_err", 32'(bus.err), 32'h0);
            end
        end
        drv_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("first_ack", 32'(bus.ack), 32'h1);
        wait_start("first_start_to");
        chk("first_grant", 32'(bus.grant_id), 32'h0);
        chk("first_data", 32'(bus.tx_data), 32'hA0);

        // Round robin with all four held high
        for (k = 0; k < 100 && starts < 5; k++) @(negedge clk);
        if (k == 100) chk("rr_to", 32'd1, 32'd0);
        drv_edge();
        bus.req = 4'b0000;
        wait_idle("rr_idle_to");
        repeat (3) @(negedge clk);
        chk("rr_starts", 32'(starts), 32'd5);
        chk("rr_acks", 32'(acks), 32'd5);
        chk("rr_nframes", 32'(frames.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_frame%0d", i), 32'(frames[i]), 32'(exp3[i]));
        chk("rr_overlap", 32'(overlap), 32'd0);
        chk("rr_unstable", 32'(unstable), 32'd0);

        // Single requester, then a follow-up waiting for the frame to finish
        drv_edge();
        bus.req_data[2] = 8'h02;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("single_ack", 32'(bus.ack), 32'h4);
        drv_edge();
        bus.req = 4'b0001;
        @(negedge clk);
        chk("single_start", 32'(bus.tx_start), 32'h1);
        chk("single_data", 32'(bus.tx_data), 32'h02);
        chk("single_grant", 32'(bus.grant_id), 32'h2);
        chk("single_noack", 32'(bus.ack), 32'h0);
        for (k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("single_pulse", 32'(bus.tx_start), 32'h0);
            if (bus.ack != 4'b0000) break;
        end
        chk("single_gap", 32'(k), 32'd12);
        chk("follow_ack", 32'(bus.ack), 32'h1);
        drv_edge();
        bus.req = 4'b0000;
        wait_start("follow_start_to");
        chk("follow_data", 32'(bus.tx_data), 32'hA0);
        wait_idle("follow_idle_to");

        drv_edge();
        bus.req_data[1] = 8'h11;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("r1_ack", 32'(bus.ack), 32'h2);
        drv_edge();
        bus.req = 4'b0000;
        @(negedge clk);
        chk("r1_data", 32'(bus.tx_data), 32'h11);
        wait_idle("r1_idle_to");

        // Contention at ptr=2, then withdrawal of the loser
        frames.delete();
        a0 = acks;
        drv_edge();
        bus.req_data[1] = 8'h5A;
        bus.req_data[3] = 8'hC3;
        bus.req = 4'b1010;
        @(negedge clk);
        chk("cont_ack", 32'(bus.ack), 32'h8);
        drv_edge();
        bus.req = 4'b0010;
        @(negedge clk);
        chk("cont_data", 32'(bus.tx_data), 32'hC3);
        repeat (3) drv_edge();
        bus.req = 4'b0000;
        wait_idle("cont_idle_to");
        repeat (5) @(negedge clk);
        chk("wd_nframes", 32'(frames.size()), 32'd1);
        chk("wd_frame", 32'(frames[0]), 32'hC3);
        chk("wd_acks", 32'(acks - a0), 32'd1);

        // Reset while WAIT_DONE, with a pending request
        drv_edge();
        bus.req_data[0] = 8'h77;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("mr_ack", 32'(bus.ack), 32'h1);
        drv_edge();
        bus.req = 4'b0000;
        @(negedge clk);
        chk("mr_start", 32'(bus.tx_start), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("mr_ack_in_rst", 32'(bus.ack), 32'h0);
        chk("mr_active_in_rst", 32'(bus.active), 32'h0);
        drv_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_active", 32'(bus.active), 32'h0);
        chk("mr_txstart", 32'(bus.tx_start), 32'h0);
        chk("mr_txdata", 32'(bus.tx_data), 32'h0);
        chk("mr_grant", 32'(bus.grant_id), 32'h0);
        chk("mr_hold_ack", 32'(bus.ack), 32'h0);
        for (k = 5; k < 40; ) begin
            @(negedge clk);
            k++;
            if (bus.ack != 4'b0000) break;
        end
        chk("mr_gap", 32'(k), 32'd11);
        drv_edge();
        bus.req = 4'b0000;
        wait_start("mr_start_to");
        chk("mr_data", 32'(bus.tx_data), 32'h77);
        wait_idle("mr_idle_to");

`ifdef TXARB_TIMEOUT_EN
        // Transmitter never goes busy
        no_busy = 1'b1;
        drv_edge();
        bus.req_data[1] = 8'h66;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("to_ack", 32'(bus.ack), 32'h2);
        drv_edge();
        bus.req = 4'b0000;
        @(negedge clk);
        chk("to_start", 32'(bus.tx_start), 32'h1);
        repeat (15) @(negedge clk);
        chk("to_err_early", 32'(bus.err), 32'h0);
        chk("to_active_early", 32'(bus.active), 32'h1);
        @(negedge clk);
        chk("to_err", 32'(bus.err), 32'h1);
        chk("to_active", 32'(bus.active), 32'h0);
        no_busy = 1'b0;
        drv_edge();
        bus.req = 4'b0100;
        @(negedge clk);
        chk("to_next_ack", 32'(bus.ack), 32'h4);
        drv_edge();
        bus.req = 4'b0000;
        wait_start("to_next_start_to");
        chk("to_next_data", 32'(bus.tx_data), 32'h02);
        wait_idle("to_idle_to");
        chk("to_err_sticky", 32'(bus.err), 32'h1);
        drv_edge();
        rst = 1'b1;
        drv_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("to_err_clr", 32'(bus.err), 32'h0);
`else
        chk("err_tied", 32'(bus.err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
